md_issue_ctrl: RTL

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_issue_ctrl_pkg.sv | 24 ++
 rtl/md_issue_ctrl_if.sv | 30 +++
 rtl/md_timeout_counter.sv | 35 +++
 rtl/md_issue_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings and constants for the multiply/divide issue controller.
package md_issue_ctrl_pkg;

  localparam int XLEN            = 32;
  localparam int TIMEOUT_DEFAULT = 40;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  function automatic logic is_md_op(input logic       valid,
                                    input logic [4:0] opcode,
                                    input logic [4:0] aluop);
    return valid && (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Execute-stage / multiply-divide unit / writeback signals of the issue controller.
interface md_issue_ctrl_if;
  import md_issue_ctrl_pkg::*;

  logic [XLEN-1:0] ir_dx;
  logic            valid_dx;
  logic            flush;
  logic            md_ready;
  logic            md_exception;
  logic [XLEN-1:0] md_result;
  logic            ctrl_mult;
  logic            ctrl_div;
  logic            stall;
  logic            busy;
  logic            wb_valid;
  logic [XLEN-1:0] wb_result;
  logic            wb_exception;
  logic [4:0]      wb_rd;

  modport slave (
    input  ir_dx, valid_dx, flush, md_ready, md_exception, md_result,
    output ctrl_mult, ctrl_div, stall, busy, wb_valid, wb_result, wb_exception, wb_rd
  );

  modport master (
    output ir_dx, valid_dx, flush, md_ready, md_exception, md_result,
    input  ctrl_mult, ctrl_div, stall, busy, wb_valid, wb_result, wb_exception, wb_rd
  );

endinterface

// File: rtl/md_timeout_counter.sv
// Saturating wait counter; tc marks the last cycle allowed before giving up.
module md_timeout_counter #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tc = (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issues mult/div ops from execute, stalls the front end until the unit answers or times out.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  md_issue_ctrl_if.slave md
);

  md_state_e       state_q, state_d;
  logic            is_mul_q, is_mul_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wb_result_q, wb_result_d;
  logic            wb_exception_q, wb_exception_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            decode;
  logic            in_idle, in_issue, in_wait, in_done;
  logic            tmo_tc;

  assign decode   = is_md_op(md.valid_dx, md.ir_dx[31:27], md.ir_dx[6:2]);
  assign in_idle  = (state_q == ST_IDLE);
  assign in_issue = (state_q == ST_ISSUE);
  assign in_wait  = (state_q == ST_WAIT);
  assign in_done  = (state_q == ST_DONE);

  md_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (in_issue),
    .enable (in_wait),
    .tc     (tmo_tc)
  );

  always_comb begin
    state_d        = state_q;
    is_mul_d       = is_mul_q;
    rd_d           = rd_q;
    wb_result_d    = wb_result_q;
    wb_exception_d = wb_exception_q;
    wb_rd_d        = wb_rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (decode && !md.flush) begin
          is_mul_d = (md.ir_dx[6:2] == ALU_MUL);
          rd_d     = md.ir_dx[26:22];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // md_ready here belongs to an older op, so it is not looked at.
        state_d = md.flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (md.flush) begin
          state_d = ST_IDLE;
        end else if (md.md_ready) begin
          wb_result_d    = md.md_result;
          wb_exception_d = md.md_exception;
          wb_rd_d        = rd_q;
          state_d        = ST_DONE;
        end else if (tmo_tc) begin
          wb_result_d    = '0;
          wb_exception_d = 1'b1;
          wb_rd_d        = rd_q;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wb_result_q    <= '0;
      wb_exception_q <= 1'b0;
      wb_rd_q        <= '0;
    end else begin
      state_q        <= state_d;
      wb_result_q    <= wb_result_d;
      wb_exception_q <= wb_exception_d;
      wb_rd_q        <= wb_rd_d;
    end
  end

  always_ff @(posedge clock) begin
    is_mul_q <= is_mul_d;
    rd_q     <= rd_d;
  end

  // Outputs are held low while reset is asserted, whatever the state register holds.
  assign md.ctrl_mult    = !reset && in_issue && !md.flush && is_mul_q;
  assign md.ctrl_div     = !reset && in_issue && !md.flush && !is_mul_q;
  assign md.stall        = !reset && ((in_idle && decode && !md.flush) || in_issue || in_wait);
  assign md.busy         = !reset && (in_issue || in_wait);
  assign md.wb_valid     = !reset && in_done && !md.flush;
  assign md.wb_result    = wb_result_q;
  assign md.wb_exception = wb_exception_q;
  assign md.wb_rd        = wb_rd_q;

endmodule
